// File: rtl/mul_add_seq_pkg.sv
// mul_add_pkg: shared state type and sizing for the shift-and-add multiply-accumulate unit
package mul_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int W_DEF = 8;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    localparam int CNT_W = cnt_w(W_DEF);
endpackage

// File: rtl/mul_add_seq_cla_add_2w.sv
// cla_add_2w: 2*W-bit adder from 4-bit CLA groups joined by a lookahead carry unit
module cla_add_2w
    import mul_add_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    input  logic           cin,
    output logic [2*W-1:0] sum,
    output logic           cout
);
    localparam int NB = 2 * W;
    localparam int NG = (NB + 3) / 4;
    localparam int PW = NG * 4;
    logic [PW-1:0] ap, bp, p, g;
    logic [PW:0]   cb;
    logic [NG-1:0] gp, gg;
    logic [NG:0]   gc;
    logic          c, pr;
    assign ap = PW'(a);
    assign bp = PW'(b);
    assign p  = ap ^ bp;
    assign g  = ap & bp;
    for (genvar i = 0; i < NG; i++) begin : g_grp
        localparam int B = 4 * i;
        assign gp[i] = &p[B+:4];
        assign gg[i] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign cb[B]   = gc[i];
        assign cb[B+1] = g[B] | (p[B] & gc[i]);
        assign cb[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
        assign cb[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & gc[i]);
    end
    // Each group carry is a flat sum of products over lower groups, not a ripple chain
    always_comb begin
        gc = '0;
        gc[0] = cin;
        c = 1'b0;
        pr = 1'b0;
        for (int i = 0; i < NG; i++) begin
            c = 1'b0;
            for (int j = 0; j <= i; j++) begin
                pr = 1'b1;
                for (int k = j + 1; k <= i; k++) pr = pr & gp[k];
                c = c | (gg[j] & pr);
            end
            pr = cin;
            for (int k = 0; k <= i; k++) pr = pr & gp[k];
            gc[i+1] = c | pr;
        end
    end
    assign cb[PW] = gc[NG];
    assign sum    = p[NB-1:0] ^ cb[NB-1:0];
    assign cout   = cb[NB];
endmodule

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential N = Q*D + R, one multiplier bit per clock, start/busy/done handshake
module mul_add_seq
    import mul_add_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   Q,
    input  logic [W-1:0]   D,
    input  logic [W-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] N,
    output logic           ovf,
    output logic           rem_err
);
    localparam int CW = cnt_w(W);
    state_t         state_q, state_d;
    logic [W-1:0]   q_sh_q, q_sh_d;
    logic [2*W-1:0] d_sh_q, d_sh_d, acc_q, acc_d, n_q, n_d, pp, sum;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d, rem_err_q, rem_err_d, rem_pend_q, rem_pend_d;
    logic           last, add_cout_unused;
    assign pp   = q_sh_q[0] ? d_sh_q : '0;
    assign last = cnt_q == CW'(W - 1);
    // Result never exceeds 2*W bits, so the carry-out is dropped
    cla_add_2w #(.W(W)) u_add (
        .a    (acc_q),
        .b    (pp),
        .cin  (1'b0),
        .sum  (sum),
        .cout (add_cout_unused)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_sh_q     <= '0;
            d_sh_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            ovf_q      <= 1'b0;
            rem_err_q  <= 1'b0;
            rem_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_sh_q     <= q_sh_d;
            d_sh_q     <= d_sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            ovf_q      <= ovf_d;
            rem_err_q  <= rem_err_d;
            rem_pend_q <= rem_pend_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? (last ? DONE : RUN)  : IDLE;
    end
    always_comb begin
        q_sh_d     = q_sh_q;
        d_sh_d     = d_sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        ovf_d      = ovf_q;
        rem_err_d  = rem_err_q;
        rem_pend_d = rem_pend_q;
        if (state_q == IDLE && start) begin
            q_sh_d     = Q;
            d_sh_d     = {{W{1'b0}}, D};
            acc_d      = {{W{1'b0}}, R};
            cnt_d      = '0;
            rem_pend_d = (D == '0) | (R >= D);
        end else if (state_q == RUN) begin
            acc_d  = sum;
            d_sh_d = d_sh_q << 1;
            q_sh_d = q_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                n_d       = sum;
                ovf_d     = |sum[2*W-1:W];
                rem_err_d = rem_pend_q;
            end
        end
    end
    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
    end
    assign N       = n_q;
    assign ovf     = ovf_q;
    assign rem_err = rem_err_q;
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: table-driven and hand-sequenced checks of mul_add_seq through a result scoreboard
module tb_mul_add_seq;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0]   q, d, r;
        logic [2*W-1:0] n;
        logic           ovf, rem;
    } vec_t;
    typedef struct {
        logic [2*W-1:0] n;
        logic           ovf, rem;
        int             k;
    } exp_t;
    logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0]   q = '0, d = '0, r = '0;
    logic           busy, done, ovf, rem_err;
    logic [2*W-1:0] n;
    int             n_cmp = 0, n_err = 0, cyc = 0;
    exp_t           sb[$];
    exp_t           mon_e;
    vec_t           vt[9];
    vec_t           v;

    mul_add_seq #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Q       (q),
        .D       (d),
        .R       (r),
        .busy    (busy),
        .done    (done),
        .N       (n),
        .ovf     (ovf),
        .rem_err (rem_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] q_i, d_i, r_i, input logic [2*W-1:0] n_i,
                                input logic o_i, e_i);
        vec_t t;
        t.q = q_i; t.d = d_i; t.r = r_i; t.n = n_i; t.ovf = o_i; t.rem = e_i;
        return t;
    endfunction

    task automatic push(input vec_t t);
        exp_t e;
        e.n = t.n; e.ovf = t.ovf; e.rem = t.rem; e.k = cyc;
        sb.push_back(e);
    endtask

    task automatic start_op(input vec_t t);
        @(negedge clk);
        q = t.q; d = t.d; r = t.r; start = 1'b1;
        @(posedge clk);
        #1;
        push(t);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * W && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_op(input vec_t t);
        start_op(t);
        drain();
        repeat (2) @(negedge clk);
        check("n_hold", n, t.n);
        check("rem_hold", rem_err, t.rem);
    endtask

    // Every done must match the oldest outstanding request; done lands W edges after the start edge
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) check("spurious_done", done, 0);
            else begin
                mon_e = sb.pop_front();
                check("n", n, mon_e.n);
                check("ovf", ovf, mon_e.ovf);
                check("rem_err", rem_err, mon_e.rem);
                check("latency", cyc - mon_e.k, W);
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        vt[0] = mk(8'd255, 8'd255, 8'd254, 16'd65279, 1'b1, 1'b0);
        vt[1] = mk(8'd5,   8'd0,   8'd3,   16'd3,     1'b0, 1'b1);
        vt[2] = mk(8'd2,   8'd4,   8'd4,   16'd12,    1'b0, 1'b1);
        vt[3] = mk(8'd0,   8'd0,   8'd0,   16'd0,     1'b0, 1'b1);
        vt[4] = mk(8'd255, 8'd1,   8'd0,   16'd255,   1'b0, 1'b0);
        vt[5] = mk(8'd16,  8'd16,  8'd0,   16'd256,   1'b1, 1'b0);
        vt[6] = mk(8'd100, 8'd7,   8'd6,   16'd706,   1'b1, 1'b0);
        vt[7] = mk(8'd1,   8'd255, 8'd255, 16'd510,   1'b1, 1'b1);
        vt[8] = mk(8'd10,  8'd20,  8'd30,  16'd230,   1'b0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_n", n, 0);
        check("rst_ovf", ovf, 0);
        check("rst_rem_err", rem_err, 0);
        rst = 1'b0;

        start_op(mk(8'd12, 8'd10, 8'd7, 16'd127, 1'b0, 1'b0));
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_run", {busy, done}, 2'b10);
        end
        @(negedge clk);
        check("done_pulse", {busy, done}, 2'b01);
        drain();
        @(negedge clk);
        check("done_drop", {busy, done}, 2'b00);

        for (int i = 0; i < 9; i++) run_op(vt[i]);

        start_op(mk(8'd3, 8'd3, 8'd0, 16'd9, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        q = 8'd77; d = 8'd5; r = 8'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("ignore_n", n, 9);

        @(negedge clk);
        q = 8'd200; d = 8'd100; r = 8'd50; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_n", n, 0);
        check("mid_rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_idle", {busy, done}, 2'b00);
        run_op(mk(8'd1, 8'd1, 8'd0, 16'd1, 1'b0, 1'b0));

        // Start held high: each later request is accepted W+2 edges after the previous one
        v = mk(8'd1, 8'd2, 8'd1, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        q = v.q; d = v.d; r = v.r; start = 1'b1;
        @(posedge clk);
        #1;
        push(v);
        v = mk(8'd0, 8'd9, 8'd8, 16'd8, 1'b0, 1'b0);
        q = v.q; d = v.d; r = v.r;
        repeat (W + 2) @(posedge clk);
        #1;
        push(v);
        v = mk(8'd16, 8'd16, 8'd15, 16'd271, 1'b1, 1'b0);
        q = v.q; d = v.d; r = v.r;
        repeat (W + 2) @(posedge clk);
        #1;
        push(v);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("b2b_final_n", n, 271);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
